// File: rtl/ir_nec_tx.sv
// NEC infrared transmitter: serialises {~cmd, cmd, ~addr, addr} LSB first as
// baseband (ir_out, active-low) and as a carrier-gated LED drive (ir_led).
module ir_nec_tx #(
  parameter int TICK_DIV    = 1,
  parameter int CARRIER_DIV = 2,
  parameter int GAP_TICKS   = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [7:0] addr,
  input  logic [7:0] cmd,
  output logic       busy,
  output logic       done,
  output logic       ir_out,
  output logic       ir_led
);

  // state      | meaning
  // IDLE       | waiting for send
  // LEAD_MARK  | 256-tick leader mark (low)
  // LEAD_SPACE | 128-tick leader space (high)
  // BIT_MARK   | 16-tick mark before each data bit
  // BIT_SPACE  | 16 (bit 0) or 48 (bit 1) tick space
  // STOP_MARK  | 16-tick closing mark
  // GAP        | GAP_TICKS idle-high ticks before busy drops
  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] LEAD_MARK  = 3'd1;
  localparam logic [2:0] LEAD_SPACE = 3'd2;
  localparam logic [2:0] BIT_MARK   = 3'd3;
  localparam logic [2:0] BIT_SPACE  = 3'd4;
  localparam logic [2:0] STOP_MARK  = 3'd5;
  localparam logic [2:0] GAP        = 3'd6;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;
  localparam int GW = $clog2(GAP_TICKS + 1);

  logic [2:0]    state;
  logic [PW-1:0] pre_cnt;
  logic [8:0]    seg_cnt;
  logic [GW-1:0] gap_cnt;
  logic [4:0]    bit_idx;
  logic [31:0]   frame;
  logic [CW-1:0] car_cnt;
  logic          carrier;

  logic       accept;
  logic       tick;
  logic [8:0] seg_len;
  logic       seg_end;
  logic       gap_end;

  // done blocks accept so the frame after a gap starts no earlier than one cycle later
  assign accept  = (state == IDLE) && send && !done;
  assign tick    = (pre_cnt == PW'(TICK_DIV - 1));
  assign seg_end = tick && (seg_cnt == seg_len - 9'd1);
  assign gap_end = tick && (gap_cnt == GW'(GAP_TICKS - 1));
  assign ir_led  = carrier & ~ir_out;

  always_comb begin
    seg_len = 9'd16;
    case (state)
      LEAD_MARK:  seg_len = 9'd256;
      LEAD_SPACE: seg_len = 9'd128;
      BIT_SPACE:  seg_len = frame[bit_idx] ? 9'd48 : 9'd16;
      default:    seg_len = 9'd16;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      car_cnt <= '0;
      carrier <= 1'b0;
    end else if (accept) begin
      car_cnt <= '0;
      carrier <= 1'b1;
    end else if (car_cnt == CW'(CARRIER_DIV - 1)) begin
      car_cnt <= '0;
      carrier <= ~carrier;
    end else begin
      car_cnt <= car_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pre_cnt <= '0;
      seg_cnt <= '0;
      gap_cnt <= '0;
      bit_idx <= '0;
      frame   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ir_out  <= 1'b1;
    end else begin
      done <= 1'b0;
      if (accept) begin
        frame   <= {~cmd, cmd, ~addr, addr};
        state   <= LEAD_MARK;
        busy    <= 1'b1;
        ir_out  <= 1'b0;
        pre_cnt <= '0;
        seg_cnt <= '0;
        gap_cnt <= '0;
        bit_idx <= '0;
      end else if (state != IDLE) begin
        pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
        if (state == GAP) begin
          if (gap_end) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            gap_cnt <= '0;
          end else if (tick) begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end else if (seg_end) begin
          seg_cnt <= '0;
          case (state)
            LEAD_MARK: begin
              state  <= LEAD_SPACE;
              ir_out <= 1'b1;
            end
            LEAD_SPACE: begin
              state  <= BIT_MARK;
              ir_out <= 1'b0;
            end
            BIT_MARK: begin
              state  <= BIT_SPACE;
              ir_out <= 1'b1;
            end
            BIT_SPACE: begin
              ir_out <= 1'b0;
              if (bit_idx == 5'd31) begin
                state <= STOP_MARK;
              end else begin
                state   <= BIT_MARK;
                bit_idx <= bit_idx + 5'd1;
              end
            end
            STOP_MARK: begin
              state  <= GAP;
              ir_out <= 1'b1;
            end
            default: begin
              state  <= IDLE;
              ir_out <= 1'b1;
            end
          endcase
        end else if (tick) begin
          seg_cnt <= seg_cnt + 9'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ir_nec_tx.sv
// Bench for ir_nec_tx: a pulse-distance decoder recovers each frame from ir_out
// and compares it against words queued when send was driven.
module tb_ir_nec_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       send = 1'b0, send2 = 1'b0;
  logic [7:0] addr = '0, cmd = '0, addr2 = '0, cmd2 = '0;
  logic       busy, done, ir_out, ir_led;
  logic       busy2, done2, ir_out2, ir_led2;

  always #5 clk = ~clk;

  ir_nec_tx #(.TICK_DIV(1), .CARRIER_DIV(2), .GAP_TICKS(4)) u_dut (
    .clk(clk), .rst(rst), .send(send), .addr(addr), .cmd(cmd),
    .busy(busy), .done(done), .ir_out(ir_out), .ir_led(ir_led)
  );

  ir_nec_tx #(.TICK_DIV(3), .CARRIER_DIV(2), .GAP_TICKS(4)) u_pre (
    .clk(clk), .rst(rst), .send(send2), .addr(addr2), .cmd(cmd2),
    .busy(busy2), .done(done2), .ir_out(ir_out2), .ir_led(ir_led2)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [31:0] exp_q[$];
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // receiver model state
  int          mphase = 0;
  int          fall_t, lead_t, nbits, per;
  int          frame_cnt = 0, done_cnt = 0, last_done_cyc = 0;
  bit          b2b_arm = 0;
  logic        prev_ir = 1'b1;
  logic [31:0] word, last_word = '0;
  logic [31:0] e;

  always @(negedge clk) begin
    if (rst) begin
      mphase  = 0;
      prev_ir = ir_out;
    end else begin
      if (prev_ir && !ir_out) begin
        if (mphase == 0) begin
          if (b2b_arm) begin
            check("b2b_restart", cyc - last_done_cyc, 2);
            b2b_arm = 0;
          end
          mphase = 1;
          fall_t = cyc;
          lead_t = cyc;
        end else if (mphase == 1) begin
          check("lead_period", cyc - fall_t, 384);
          mphase = 2;
          nbits  = 0;
          fall_t = cyc;
        end else if (nbits < 32) begin
          per = cyc - fall_t;
          check("bit_period_legal", (per == 32) || (per == 64), 1);
          word[nbits] = (per == 64);
          nbits++;
          fall_t = cyc;
        end
      end
      if (!prev_ir && ir_out) begin
        if (mphase == 1) begin
          check("lead_mark", cyc - fall_t, 256);
        end else if (mphase == 2 && nbits == 32) begin
          check("stop_mark", cyc - fall_t, 16);
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("frame_word", word, e);
          end
          last_word = word;
          frame_cnt++;
          mphase = 0;
        end else if (mphase == 2 && (cyc - fall_t) != 16) begin
          check("bit_mark", cyc - fall_t, 16);
        end
      end
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
        check("done_latency", cyc - lead_t, 1940);
        check("busy_low_at_done", busy, 0);
      end
      prev_ir = ir_out;
    end
  end

  task automatic send_frame(input logic [7:0] a, input logic [7:0] c, input bit queued);
    @(negedge clk);
    addr = a;
    cmd  = c;
    send = 1'b1;
    if (queued) exp_q.push_back({~c, c, ~a, a});
    @(negedge clk);
    send = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int t = 0;
    while (done !== 1'b1 && t < limit) begin
      @(negedge clk);
      t++;
    end
    if (t >= limit) check("done_timeout", 0, 1);
  endtask

  task automatic wait_busy(input int limit);
    int t = 0;
    while (busy !== 1'b1 && t < limit) begin
      @(negedge clk);
      t++;
    end
    if (t >= limit) check("busy_timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, lo, led_err, t, dc;
    logic exp_led;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_ir_out", ir_out, 1);
    check("rst_ir_led", ir_led, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // reset mid lead mark aborts asynchronously
    send_frame(8'h12, 8'h34, 0);
    repeat (100) @(negedge clk);
    check("pre_abort_ir_out", ir_out, 0);
    dc = done_cnt;
    #2 rst = 1'b1;
    #1;
    check("abort_ir_out_async", ir_out, 1);
    check("abort_busy_async", busy, 0);
    repeat (3) @(negedge clk);
    check("abort_ir_led", ir_led, 0);
    rst = 1'b0;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy !== 1'b0 || ir_out !== 1'b1 || done !== 1'b0) bad++;
    end
    check("idle_after_abort", bad, 0);
    check("no_done_on_abort", done_cnt, dc);

    // golden frame
    send_frame(8'h00, 8'h45, 1);
    wait_done(3000);
    repeat (3) @(negedge clk);
    check("golden_frames", frame_cnt, 1);

    // send while busy is ignored, mid-frame addr/cmd changes have no effect
    send_frame(8'h33, 8'hCC, 1);
    repeat (8) @(negedge clk);
    send_frame(8'h99, 8'h11, 0);
    repeat (990) @(negedge clk);
    send_frame(8'h77, 8'h88, 0);
    wait_done(3000);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (busy !== 1'b0) bad++;
    end
    check("busy_ignore_no_requeue", bad, 0);
    check("busy_ignore_frames", frame_cnt, 2);

    // back-to-back with send held high
    @(negedge clk);
    addr = 8'h21;
    cmd  = 8'hFF;
    send = 1'b1;
    exp_q.push_back({8'h00, 8'hFF, 8'hDE, 8'h21});
    wait_busy(10);
    cmd = 8'h00;
    exp_q.push_back({8'hFF, 8'h00, 8'hDE, 8'h21});
    wait_done(3000);
    b2b_arm = 1;
    @(negedge clk);
    wait_busy(10);
    send = 1'b0;
    wait_done(3000);
    repeat (3) @(negedge clk);
    check("b2b_frames", frame_cnt, 4);
    check("b2b_second_cmd", last_word[23:16], 8'h00);

    // loopback into the receiver model
    send_frame(8'h10, 8'h5A, 1);
    wait_done(3000);
    repeat (3) @(negedge clk);
    check("loopback_key", last_word[23:16], 8'h5A);
    check("loopback_key_inv", last_word[31:24], 8'hA5);

    // prescaler and carrier on the TICK_DIV=3 instance
    @(negedge clk);
    addr2 = 8'h01;
    cmd2  = 8'h02;
    send2 = 1'b1;
    @(negedge clk);
    send2 = 1'b0;
    t = 0;
    while (ir_out2 !== 1'b0 && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("pre_start", ir_out2, 0);
    lo = 0;
    led_err = 0;
    while (ir_out2 === 1'b0 && lo < 2000) begin
      exp_led = ((lo / 2) % 2) == 0;
      if (ir_led2 !== exp_led) led_err++;
      lo++;
      @(negedge clk);
    end
    check("pre_lead_mark", lo, 768);
    check("carrier_pattern", led_err, 0);
    bad = 0;
    repeat (100) begin
      if (ir_out2 === 1'b1 && ir_led2 !== 1'b0) bad++;
      @(negedge clk);
    end
    check("led_off_in_space", bad, 0);
    t = 0;
    while (done2 !== 1'b1 && t < 8000) begin
      @(negedge clk);
      t++;
    end
    check("pre_done_seen", done2, 1);
    check("pre_busy_at_done", busy2, 0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
